// File: rtl/rps_draw_scheduler.sv
// Arbitrates user/computer sprite redraws, walks the 80x120 sprite region over the
// shared 1-bit sprite ROMs, and drives the vga_adapter two cycles behind the address.
module rps_draw_scheduler #(
    parameter int SPRITE_W = 80,
    parameter int SPRITE_H = 120,
    parameter int USER_X0  = 80,
    parameter int COMP_X0  = 0
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        req_user,
    input  logic [1:0]  choice_user,
    input  logic        req_comp,
    input  logic [1:0]  choice_comp,
    output logic        gnt_user,
    output logic        gnt_comp,
    output logic        busy,
    output logic        done,
    output logic [13:0] rom_addr,
    output logic [1:0]  rom_sel,
    input  logic        rom_q,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    localparam logic [6:0] XL_LAST = 7'(SPRITE_W - 1);
    localparam logic [6:0] YL_LAST = 7'(SPRITE_H - 1);
    localparam logic [7:0] USER_X  = 8'(USER_X0);
    localparam logic [7:0] COMP_X  = 8'(COMP_X0);

    state_t     state;
    logic [6:0] xl;
    logic [6:0] yl;
    logic       side_comp;
    logic       prefer_user;
    logic       flush_cnt;

    logic       s1_valid;
    logic       s1_comp;
    logic [7:0] s1_x;
    logic [6:0] s1_y;

    // Paper has two encodings; only the ROM mux codes 00/01/10 are ever driven.
    function automatic logic [1:0] map_choice(input logic [1:0] c);
        return (c == 2'b11) ? 2'b10 : c;
    endfunction

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order in the block.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= IDLE;
            xl          <= '0;
            yl          <= '0;
            side_comp   <= 1'b0;
            prefer_user <= 1'b1;
            flush_cnt   <= 1'b0;
            gnt_user    <= 1'b0;
            gnt_comp    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rom_addr    <= '0;
            rom_sel     <= '0;
        end else begin
            gnt_user <= 1'b0;
            gnt_comp <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_user && (prefer_user || !req_comp)) begin
                        gnt_user    <= 1'b1;
                        busy        <= 1'b1;
                        side_comp   <= 1'b0;
                        rom_sel     <= map_choice(choice_user);
                        prefer_user <= 1'b0;
                        xl          <= '0;
                        yl          <= '0;
                        rom_addr    <= '0;
                        state       <= DRAW;
                    end else if (req_comp) begin
                        gnt_comp    <= 1'b1;
                        busy        <= 1'b1;
                        side_comp   <= 1'b1;
                        rom_sel     <= map_choice(choice_comp);
                        prefer_user <= 1'b1;
                        xl          <= '0;
                        yl          <= '0;
                        rom_addr    <= '0;
                        state       <= DRAW;
                    end
                end
                DRAW: begin
                    // Address tracks yl*SPRITE_W+xl incrementally; no multiplier needed.
                    rom_addr <= rom_addr + 14'd1;
                    if (xl == XL_LAST) begin
                        xl <= '0;
                        if (yl == YL_LAST) begin
                            rom_addr  <= '0;
                            flush_cnt <= 1'b0;
                            state     <= FLUSH;
                        end else begin
                            yl <= yl + 7'd1;
                        end
                    end else begin
                        xl <= xl + 7'd1;
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1 lines up with rom_q (one cycle after its address); stage 2 is the VGA output.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_comp  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            plot     <= 1'b0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
        end else begin
            s1_valid <= (state == DRAW);
            s1_comp  <= side_comp;
            s1_x     <= (side_comp ? COMP_X : USER_X) + {1'b0, xl};
            s1_y     <= yl;
            plot     <= s1_valid;
            if (s1_valid) begin
                x      <= s1_x;
                y      <= s1_y;
                colour <= rom_q ? (s1_comp ? 3'b111 : 3'b000) : 3'b010;
            end else begin
                x      <= '0;
                y      <= '0;
                colour <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rps_draw_scheduler.sv
// Scoreboard bench for rps_draw_scheduler: expected pixel streams are queued per job
// and popped as plot cycles appear; timing, arbitration and reset are checked per test.
module tb_rps_draw_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        req_user;
    logic [1:0]  choice_user;
    logic        req_comp;
    logic [1:0]  choice_comp;
    logic        gnt_user;
    logic        gnt_comp;
    logic        busy;
    logic        done;
    logic [13:0] rom_addr;
    logic [1:0]  rom_sel;
    logic        rom_q;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    int checks   = 0;
    int failures = 0;
    int rom_pattern = 0;

    typedef struct {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t exp_q[$];

    // Per-job observations, filled in by collect_job.
    int         job_wait, job_side, job_gnt_cnt, job_busy_cnt, job_done;
    int         job_first_plot, job_last_plot, job_plot_cnt, job_pix_errs;
    logic [7:0] job_first_x, job_last_x, job_x82, job_x83;
    logic [6:0] job_first_y, job_last_y;
    logic [13:0] job_addr79, job_addr80;
    logic [1:0] job_sel;
    bit         job_sel_changed;
    string      job_bad;

    rps_draw_scheduler dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .req_user    (req_user),
        .choice_user (choice_user),
        .req_comp    (req_comp),
        .choice_comp (choice_comp),
        .gnt_user    (gnt_user),
        .gnt_comp    (gnt_comp),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_sel     (rom_sel),
        .rom_q       (rom_q),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic rom_bit(input logic [13:0] a, input logic [1:0] s, input int pat);
        case (pat)
            0:       return 1'b1;
            1:       return 1'b0;
            default: return a[0] ^ a[6] ^ s[0];
        endcase
    endfunction

    // Synchronous ROM model with one cycle of read latency.
    always @(posedge CLOCK_50) rom_q <= rom_bit(rom_addr, rom_sel, rom_pattern);

    task automatic push_job(input bit comp_side, input logic [1:0] choice);
        logic [1:0]  sel;
        logic [13:0] a;
        pix_t        p;
        sel = (choice == 2'b11) ? 2'b10 : choice;
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 80; xx++) begin
                a    = 14'(yy * 80 + xx);
                p.px = 8'((comp_side ? 0 : 80) + xx);
                p.py = 7'(yy);
                p.pc = rom_bit(a, sel, rom_pattern) ? (comp_side ? 3'b111 : 3'b000) : 3'b010;
                exp_q.push_back(p);
            end
        end
    endtask

    // Waits (bounded) for a grant, then records one job up to its done pulse.
    // n counts observed cycles after the sampling edge k, so n == 1 is cycle k+1.
    task automatic collect_job(input bit drop, input int toggle_at);
        int   w;
        int   n;
        bit   got;
        bit   fin;
        pix_t e;
        job_wait = -1; job_side = -1; job_gnt_cnt = 0; job_busy_cnt = 0; job_done = -1;
        job_first_plot = -1; job_last_plot = -1; job_plot_cnt = 0; job_pix_errs = 0;
        job_sel_changed = 0; job_bad = "none";
        got = 0;
        w   = 0;
        while (!got && w < 20) begin
            @(negedge CLOCK_50);
            w++;
            if (gnt_user || gnt_comp) got = 1;
        end
        if (got) begin
            job_wait = w;
            job_side = gnt_comp ? 1 : 0;
            n   = 0;
            fin = 0;
            while (!fin && n < 9700) begin
                if (n > 0) @(negedge CLOCK_50);
                n++;
                if (n == 1 && drop) begin
                    if (gnt_user) req_user = 1'b0;
                    if (gnt_comp) req_comp = 1'b0;
                end
                if (gnt_user || gnt_comp) job_gnt_cnt++;
                if (busy) job_busy_cnt++;
                if (n == 1) job_sel = rom_sel;
                else if (rom_sel !== job_sel) job_sel_changed = 1;
                if (n == 80) job_addr79 = rom_addr;
                if (n == 81) job_addr80 = rom_addr;
                if (n == 82) job_x82 = x;
                if (n == 83) job_x83 = x;
                if (n == toggle_at) choice_comp = ~choice_comp;
                if (plot) begin
                    if (job_first_plot < 0) begin
                        job_first_plot = n;
                        job_first_x    = x;
                        job_first_y    = y;
                    end
                    job_last_plot = n;
                    job_last_x    = x;
                    job_last_y    = y;
                    job_plot_cnt++;
                    if (exp_q.size() == 0) begin
                        if (job_pix_errs == 0) job_bad = $sformatf("n=%0d unexpected pixel", n);
                        job_pix_errs++;
                    end else begin
                        e = exp_q.pop_front();
                        if ({x, y, colour} !== {e.px, e.py, e.pc}) begin
                            if (job_pix_errs == 0)
                                job_bad = $sformatf("n=%0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                                                    n, x, y, colour, e.px, e.py, e.pc);
                            job_pix_errs++;
                        end
                    end
                end
                if (done) begin
                    job_done = n;
                    fin      = 1;
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge CLOCK_50);
        reset = 1'b1; req_user = 1'b0; req_comp = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        reset = 1'b1; req_user = 1'b0; req_comp = 1'b0; choice_user = 2'b00; choice_comp = 2'b00;
        @(negedge CLOCK_50);
        checks++;
        if ({gnt_user, gnt_comp, busy, done, rom_addr, rom_sel, x, y, colour, plot} !== 39'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0",
                     {gnt_user, gnt_comp, busy, done, rom_addr, rom_sel, x, y, colour, plot});
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_user_job();
        rom_pattern = 2;
        @(negedge CLOCK_50);
        req_user = 1'b1; choice_user = 2'b00;
        push_job(1'b0, 2'b00);
        collect_job(1'b1, 0);
        checks++; if (job_wait !== 1)   begin failures++; $display("FAIL user_gnt_latency: got %0d want 1", job_wait); end
        checks++; if (job_side !== 0)   begin failures++; $display("FAIL user_gnt_side: got %0d want 0", job_side); end
        checks++; if (job_gnt_cnt !== 1) begin failures++; $display("FAIL user_gnt_pulses: got %0d want 1", job_gnt_cnt); end
        checks++; if (job_sel !== 2'b00) begin failures++; $display("FAIL user_rom_sel: got %0d want 0", job_sel); end
        checks++; if (job_first_plot !== 3) begin failures++; $display("FAIL user_first_plot: got %0d want 3", job_first_plot); end
        checks++; if ({job_first_x, job_first_y} !== {8'd80, 7'd0}) begin
            failures++; $display("FAIL user_first_xy: got %0d,%0d want 80,0", job_first_x, job_first_y); end
        checks++; if (job_last_plot !== 9602) begin failures++; $display("FAIL user_last_plot: got %0d want 9602", job_last_plot); end
        checks++; if ({job_last_x, job_last_y} !== {8'd159, 7'd119}) begin
            failures++; $display("FAIL user_last_xy: got %0d,%0d want 159,119", job_last_x, job_last_y); end
        checks++; if (job_done !== 9603) begin failures++; $display("FAIL user_done_cycle: got %0d want 9603", job_done); end
        checks++; if (job_plot_cnt !== 9600) begin failures++; $display("FAIL user_plot_count: got %0d want 9600", job_plot_cnt); end
        checks++; if (job_busy_cnt !== 9603) begin failures++; $display("FAIL user_busy_cycles: got %0d want 9603", job_busy_cnt); end
        checks++; if (job_pix_errs !== 0) begin failures++; $display("FAIL user_pixels: got %0d bad (%s) want 0", job_pix_errs, job_bad); end
        checks++; if ({job_addr79, job_addr80} !== {14'd79, 14'd80}) begin
            failures++; $display("FAIL row_wrap_addr: got %0d,%0d want 79,80", job_addr79, job_addr80); end
        checks++; if ({job_x82, job_x83} !== {8'd159, 8'd80}) begin
            failures++; $display("FAIL row_wrap_x: got %0d,%0d want 159,80", job_x82, job_x83); end
        @(negedge CLOCK_50);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL user_idle_after_done: got busy=%0d want 0", busy); end
    endtask

    task automatic test_comp_colour();
        rom_pattern = 0;
        @(negedge CLOCK_50);
        req_comp = 1'b1; choice_comp = 2'b01;
        push_job(1'b1, 2'b01);
        collect_job(1'b1, 0);
        checks++; if (job_side !== 1) begin failures++; $display("FAIL comp_gnt_side: got %0d want 1", job_side); end
        checks++; if (job_sel !== 2'b01) begin failures++; $display("FAIL comp_rom_sel: got %0d want 1", job_sel); end
        checks++; if (job_plot_cnt !== 9600) begin failures++; $display("FAIL comp_plot_count: got %0d want 9600", job_plot_cnt); end
        checks++; if (job_pix_errs !== 0) begin failures++; $display("FAIL comp_bg_pixels: got %0d bad (%s) want 0", job_pix_errs, job_bad); end
    endtask

    task automatic test_choice_clamp();
        rom_pattern = 1;
        @(negedge CLOCK_50);
        req_comp = 1'b1; choice_comp = 2'b11;
        push_job(1'b1, 2'b11);
        collect_job(1'b1, 3000);
        checks++; if (job_sel !== 2'b10) begin failures++; $display("FAIL clamp_rom_sel: got %0d want 2", job_sel); end
        checks++; if (job_sel_changed !== 1'b0) begin failures++; $display("FAIL clamp_sel_stable: got changed=%0d want 0", job_sel_changed); end
        checks++; if (job_pix_errs !== 0) begin failures++; $display("FAIL comp_fg_pixels: got %0d bad (%s) want 0", job_pix_errs, job_bad); end
        checks++; if (job_done !== 9603) begin failures++; $display("FAIL clamp_done_cycle: got %0d want 9603", job_done); end
    endtask

    task automatic test_arbitration();
        apply_reset();
        rom_pattern = 2;
        req_user = 1'b1; choice_user = 2'b01;
        req_comp = 1'b1; choice_comp = 2'b00;
        push_job(1'b0, 2'b01);
        collect_job(1'b0, 0);
        checks++; if ({job_side, job_wait} !== {32'd0, 32'd1}) begin
            failures++; $display("FAIL arb_first: got side=%0d wait=%0d want side=0 wait=1", job_side, job_wait); end
        checks++; if (job_pix_errs !== 0) begin failures++; $display("FAIL arb_first_pixels: got %0d bad (%s) want 0", job_pix_errs, job_bad); end
        push_job(1'b1, 2'b00);
        collect_job(1'b0, 0);
        checks++; if ({job_side, job_wait} !== {32'd1, 32'd2}) begin
            failures++; $display("FAIL arb_second: got side=%0d wait=%0d want side=1 wait=2", job_side, job_wait); end
        checks++; if (job_pix_errs !== 0) begin failures++; $display("FAIL arb_second_pixels: got %0d bad (%s) want 0", job_pix_errs, job_bad); end
        push_job(1'b0, 2'b01);
        collect_job(1'b0, 0);
        req_user = 1'b0; req_comp = 1'b0;
        checks++; if ({job_side, job_wait} !== {32'd0, 32'd2}) begin
            failures++; $display("FAIL arb_third: got side=%0d wait=%0d want side=0 wait=2", job_side, job_wait); end
        checks++; if (job_gnt_cnt !== 1) begin failures++; $display("FAIL arb_third_pulses: got %0d want 1", job_gnt_cnt); end
    endtask

    task automatic test_reset_mid_draw();
        int  w;
        bit  hit;
        apply_reset();
        req_user = 1'b1; choice_user = 2'b00;
        hit = 0;
        w   = 0;
        while (!hit && w < 6000) begin
            @(negedge CLOCK_50);
            w++;
            if (gnt_user) req_user = 1'b0;
            if (busy && rom_addr == 14'd5000) hit = 1;
        end
        checks++; if (!hit) begin failures++; $display("FAIL reach_addr_5000: got timeout want address 5000"); end
        reset = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if ({gnt_user, gnt_comp, busy, done, rom_addr, rom_sel, x, y, colour, plot} !== 39'd0) begin
            failures++;
            $display("FAIL mid_draw_reset_outputs: got %h want 0",
                     {gnt_user, gnt_comp, busy, done, rom_addr, rom_sel, x, y, colour, plot});
        end
        reset = 1'b0; req_user = 1'b1; req_comp = 1'b1;
        @(negedge CLOCK_50);
        checks++; if ({gnt_user, gnt_comp} !== 2'b10) begin
            failures++; $display("FAIL post_reset_pointer: got user=%0d comp=%0d want user=1 comp=0", gnt_user, gnt_comp); end
        apply_reset();
    endtask

    initial begin
        reset = 1'b1; req_user = 1'b0; req_comp = 1'b0; choice_user = 2'b00; choice_comp = 2'b00;
        test_reset();
        test_user_job();
        test_comp_colour();
        test_choice_clamp();
        test_arbitration();
        test_reset_mid_draw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rps_draw_scheduler.md
# rps_draw_scheduler

Sequences and arbitrates sprite redraws for the rock-paper-scissors display. Two requesters, user and computer, each ask for their half of the 160x120 frame to be painted with a chosen sprite. The block grants one requester at a time, walks the 80x120 sprite region, and addresses the shared 1-bit sprite ROMs. It then drives x/y/colour/plot into the vga_adapter, compensating for ROM read latency.

## Interface
Parameters:
- SPRITE_W, 80: sprite width in pixels.
- SPRITE_H, 120: sprite height in pixels.
- USER_X0, 80: x origin of the user half.
- COMP_X0, 0: x origin of the computer half.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_user  in  1  level request; held until gnt_user.
- choice_user  in  2  user sprite: 00 rock, 01 scissor, 10/11 paper.
- req_comp  in  1  level request; held until gnt_comp.
- choice_comp  in  2  computer sprite, same encoding.
- gnt_user  out  1  one-cycle pulse: user request accepted.
- gnt_comp  out  1  one-cycle pulse: computer request accepted.
- busy  out  1  high from grant cycle through done cycle inclusive.
- done  out  1  one-cycle pulse: last pixel plotted.
- rom_addr  out  14  sprite ROM address, yl*SPRITE_W+xl.
- rom_sel  out  2  ROM mux select: 00 rock, 01 scissor, 10 paper (11 never driven).
- rom_q  in  1  selected ROM data; 1 = background, 0 = sprite.
- x  out  8  VGA x coordinate.
- y  out  7  VGA y coordinate.
- colour  out  3  VGA colour.
- plot  out  1  VGA write enable.

## Operation
- FSM states: IDLE, DRAW, FLUSH, DONE.
- IDLE:
  - When any request is pending at an edge: pulse the winner's gnt, latch side and choice (11→10), go to DRAW, set rom_addr=0 with xl=yl=0.
  - Both pending: winner is the side not served last. The pointer favours user after reset.
- DRAW:
  - Each cycle xl increments; at xl=SPRITE_W-1, xl wraps to 0 and yl increments.
  - rom_addr is incremented by 1 each cycle (no multiplier). It equals yl*SPRITE_W+xl.
  - After address 9599 (xl=79, yl=119), go to FLUSH.
- FLUSH: 2 cycles draining the pipeline, then DONE.
- DONE: done=1 for one cycle, then IDLE. Requests are not sampled in FLUSH or DONE.
- Pixel stage:
  - x = X0(side)+xl and y = yl, delayed two cycles.
  - colour: rom_q=0 → 3'b010. rom_q=1 → 3'b000 for user side, 3'b111 for computer side.
  - plot=1 only for the valid delayed pixels: exactly SPRITE_W*SPRITE_H cycles per job.
- Choice inputs are ignored after grant. Changing them mid-draw has no effect.
- Reset behaviour:
  - Any cycle, including mid-DRAW: state←IDLE, pointer←user, pipeline cleared.
  - All outputs 0 in the cycle after the reset edge: gnt*, busy, done, rom_addr, rom_sel, x, y, colour, plot.

## Timing
- Edge k samples a request in IDLE. gnt and busy are high in cycle k+1. rom_addr=0 is also presented in cycle k+1.
- ROM latency is 1 cycle: rom_q for the address of cycle t is valid in cycle t+1.
- x/y/colour/plot for the address of cycle t are registered outputs in cycle t+2.
- Addresses run in cycles k+1..k+9600. plot is high in cycles k+3..k+9602.
- FLUSH occupies cycles k+9601..k+9602, DONE cycle k+9603, IDLE from k+9604.
- The earliest next grant pulse is at k+9605.
- A request asserted during DONE is sampled at the edge ending the first IDLE cycle.
- Job length: 9603 cycles of busy.

## Test plan
- Reset → all outputs 0. Set req_user=1, choice_user=00 at edge k → required:
  - gnt_user pulse in k+1 only, rom_sel=00.
  - First plot in k+3 with x=80, y=0.
  - Last plot in k+9602 with x=159, y=119.
  - done in k+9603.
  - 9600 plot cycles.
- Computer job, choice 01, rom_q held 1 → every plotted colour=111, x in 0..79. With rom_q=0 → colour=010.
- req_user and req_comp both high from reset → user granted first, computer granted at the first IDLE sample after done. After that, with both held high again, grants alternate.
- choice_comp=11 → rom_sel=10. Toggling choice_comp mid-DRAW leaves rom_sel unchanged.
- Row wrap check → rom_addr=79 at (xl=79, yl=0), then 80 at (0, 1). Plotted x jumps 159→80 for user.
- Assert reset at DRAW address 5000 → next cycle all outputs 0, state IDLE. A simultaneous req_comp/req_user afterwards grants user first.
